// File: rtl/serial_pkg.sv
// Shared definitions for the serializer / deserializer link pair.
// Contents: FSM state encoding, default word width, default bit order.
// No logic; imported by serializer and its companion deserializer.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPW  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH     = 8;
  localparam bit DEFAULT_MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_hold_reg.sv
// One-entry holding buffer between the word producer and the shifter.
// Ports: clk/rst (async active-high), d + accept write the entry,
//        take empties it; q is the held word, full marks it occupied.
module serial_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             accept,
  input  logic             take,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  // accept and take never coincide: the producer only sees ready while
  // the entry is empty, and take only fires while it is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (take) begin
      full <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
      q    <= d;
    end
  end

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial transmitter: WIDTH-bit words in via valid/ready,
// one bit per clock out on out_bit qualified by out_enable, out_done on the
// last bit of each word, out_busy while anything is held or in flight.
// First bit appears two edges after accept; GAP idle cycles follow each word.
module serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = DEFAULT_MSB_FIRST,
  parameter int GAP       = 0
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             out_ready,
  output logic             out_bit,
  output logic             out_enable,
  output logic             out_done,
  output logic             out_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GCNT_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             accept;
  logic             take;

  state_t           state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d, sreg_shifted;
  logic [CW-1:0]    cnt, cnt_d;
  logic [GW-1:0]    gcnt, gcnt_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             load;

  // Ready is masked by reset directly so nothing is accepted while held in reset.
  assign out_ready = ~hold_full & ~in_reset;
  assign accept    = in_valid & out_ready;

  serial_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk    (in_clock),
    .rst    (in_reset),
    .d      (in_data),
    .accept (accept),
    .take   (take),
    .q      (hold_data),
    .full   (hold_full)
  );

  // The bit on the wire is always the leading end of the shift register;
  // the register is zeroed whenever no word is in flight so out_bit idles low.
  assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign out_bit      = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign out_enable   = en_q;
  assign out_done     = done_q;
  assign out_busy     = (state != IDLE) | hold_full;

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      gcnt   <= '0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      sreg   <= sreg_d;
      cnt    <= cnt_d;
      gcnt   <= gcnt_d;
      en_q   <= en_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    sreg_d  = sreg;
    cnt_d   = cnt;
    gcnt_d  = gcnt;
    en_d    = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    take    = 1'b0;

    case (state)
      IDLE: begin
        if (hold_full) load = 1'b1;
      end
      SHIFT: begin
        if (cnt != CNT_LAST) begin
          sreg_d = sreg_shifted;
          cnt_d  = cnt + CW'(1);
          en_d   = 1'b1;
          done_d = ((cnt + CW'(1)) == CNT_LAST);
        end else begin
          // Last bit is leaving the wire on this edge.
          sreg_d = '0;
          cnt_d  = '0;
          if (GAP > 0) begin
            state_d = GAPW;
            gcnt_d  = '0;
          end else if (hold_full) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAPW: begin
        if (gcnt == GCNT_LAST) begin
          gcnt_d = '0;
          if (hold_full) load = 1'b1;
          else           state_d = IDLE;
        end else begin
          gcnt_d = gcnt + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Common word-load path from IDLE, end of SHIFT, or end of GAPW.
    if (load) begin
      take    = 1'b1;
      sreg_d  = hold_data;
      cnt_d   = '0;
      en_d    = 1'b1;
      state_d = SHIFT;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: two instances (MSB-first/GAP=0 and LSB-first/GAP=2)
// driven by directed and random words, checked against a word-level model.
module tb_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data  [2];
  logic       valid [2];
  logic       rdy   [2];
  logic       obit  [2];
  logic       oen   [2];
  logic       odone [2];
  logic       obusy [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) d0 (
    .in_clock(clk), .in_reset(rst), .in_data(data[0]), .in_valid(valid[0]),
    .out_ready(rdy[0]), .out_bit(obit[0]), .out_enable(oen[0]),
    .out_done(odone[0]), .out_busy(obusy[0]));

  serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(2)) d1 (
    .in_clock(clk), .in_reset(rst), .in_data(data[1]), .in_valid(valid[1]),
    .out_ready(rdy[1]), .out_bit(obit[1]), .out_enable(oen[1]),
    .out_done(odone[1]), .out_busy(obusy[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Word-level reference: words enter these queues when accepted and must
  // emerge, in order, exactly once, as WIDTH contiguous enabled bits.
  logic [7:0] expq0[$];
  logic [7:0] expq1[$];
  int         acc_cyc    [2];
  int         cur_n      [2];
  logic [7:0] cur_w      [2];
  int         cur_start  [2];
  logic       cur_fb     [2];
  int         last_start [2];
  int         last_end   [2];
  int         prev_end   [2];
  logic [7:0] last_word  [2];
  logic       last_fb    [2];
  bit         have_end   [2];
  int         rx_cnt     [2];

  task automatic push_exp(input int k, input logic [7:0] w);
    if (k == 0) expq0.push_back(w);
    else        expq1.push_back(w);
  endtask

  task automatic mon(input int k);
    int idx;
    int qsz;
    logic [7:0] e;
    chk($sformatf("done_wo_en%0d", k), {31'b0, odone[k] & ~oen[k]}, 32'd0);
    if (rst) begin
      cur_n[k]    = 0;
      cur_w[k]    = '0;
      have_end[k] = 1'b0;
    end else if (oen[k]) begin
      if (cur_n[k] == 0) begin
        cur_start[k] = cyc;
        cur_fb[k]    = obit[k];
        if (k == 1 && have_end[1])
          chk("gap_min1", {31'b0, (cyc - last_end[1]) >= 3}, 32'd1);
      end
      idx = (k == 0) ? 7 - cur_n[k] : cur_n[k];
      if (cur_n[k] < 8) cur_w[k][idx] = obit[k];
      cur_n[k]++;
      if (odone[k]) begin
        chk($sformatf("word_len%0d", k), cur_n[k], 32'd8);
        qsz = (k == 0) ? expq0.size() : expq1.size();
        chk($sformatf("exp_avail%0d", k), {31'b0, qsz != 0}, 32'd1);
        if (qsz != 0) begin
          e = (k == 0) ? expq0.pop_front() : expq1.pop_front();
          chk($sformatf("word%0d", k), {24'b0, cur_w[k]}, {24'b0, e});
        end
        prev_end[k]   = last_end[k];
        last_start[k] = cur_start[k];
        last_end[k]   = cyc;
        last_word[k]  = cur_w[k];
        last_fb[k]    = cur_fb[k];
        have_end[k]   = 1'b1;
        rx_cnt[k]++;
        cur_n[k] = 0;
        cur_w[k] = '0;
      end else begin
        chk($sformatf("in_word%0d", k), {31'b0, cur_n[k] < 8}, 32'd1);
      end
    end else if (cur_n[k] != 0) begin
      chk($sformatf("contig%0d", k), cur_n[k], 32'd0);
      cur_n[k] = 0;
      cur_w[k] = '0;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon(k);
  end

  // Present a word and hold it until the DUT takes it.
  task automatic send(input int k, input logic [7:0] w);
    int n;
    n = 0;
    data[k]  = w;
    valid[k] = 1'b1;
    while (!rdy[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (rdy[k]) begin
      push_exp(k, w);
      acc_cyc[k] = cyc;
      @(negedge clk);
    end else begin
      chk("send_timeout", n, 32'd0);
    end
    valid[k] = 1'b0;
    data[k]  = 8'($urandom);
  endtask

  task automatic wait_rx(input int k, input int target, input int budget);
    int n;
    n = 0;
    while (rx_cnt[k] < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("rx_count%0d", k), rx_cnt[k], target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int en_seen;
    int n;
    int b0, b1;
    for (int k = 0; k < 2; k++) begin
      data[k] = '0; valid[k] = 1'b0; cur_n[k] = 0; cur_w[k] = '0;
      rx_cnt[k] = 0; have_end[k] = 1'b0; last_end[k] = 0; prev_end[k] = 0;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", {31'b0, rdy[0]}, 32'd0);
    chk("rst_en",    {31'b0, oen[0]}, 32'd0);
    chk("rst_bit",   {31'b0, obit[0]}, 32'd0);
    chk("rst_done",  {31'b0, odone[0]}, 32'd0);
    chk("rst_busy",  {31'b0, obusy[0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready0", {31'b0, rdy[0]}, 32'd1);
    chk("rel_ready1", {31'b0, rdy[1]}, 32'd1);

    // Single word, MSB first
    send(0, 8'hA5);
    wait_rx(0, 1, 50);
    chk("lat_first", last_start[0] - acc_cyc[0], 32'd2);
    chk("en_span",   last_end[0] - last_start[0], 32'd7);
    chk("word_a5",   {24'b0, last_word[0]}, 32'h0A5);
    @(negedge clk);
    chk("idle_busy", {31'b0, obusy[0]}, 32'd0);
    chk("idle_en",   {31'b0, oen[0]}, 32'd0);

    // Back-to-back, no bubble
    send(0, 8'hA5);
    send(0, 8'h3C);
    wait_rx(0, 3, 60);
    chk("b2b_contig", last_start[0] - prev_end[0], 32'd1);
    chk("word_3c", {24'b0, last_word[0]}, 32'h03C);

    // GAP=2, LSB first
    send(1, 8'h01);
    send(1, 8'hA5);
    wait_rx(1, 1, 60);
    chk("lsb_first_bit", {31'b0, last_fb[1]}, 32'd1);
    chk("word_01", {24'b0, last_word[1]}, 32'h001);
    wait_rx(1, 2, 60);
    chk("gap2", last_start[1] - prev_end[1], 32'd3);
    chk("word_a5_lsb", {24'b0, last_word[1]}, 32'h0A5);
    repeat (4) @(negedge clk);

    // Reset mid-word with a word held
    rc = rx_cnt[0];
    send(0, 8'hF0);
    send(0, 8'h55);
    n = 0;
    while (cur_n[0] < 3 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_bits", cur_n[0], 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("mr_en",    {31'b0, oen[0]}, 32'd0);
    chk("mr_bit",   {31'b0, obit[0]}, 32'd0);
    chk("mr_ready", {31'b0, rdy[0]}, 32'd0);
    chk("mr_busy",  {31'b0, obusy[0]}, 32'd0);
    expq0.delete();
    expq1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("mr_rel_ready", {31'b0, rdy[0]}, 32'd1);
    en_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (oen[0]) en_seen++;
    end
    chk("no_residue", en_seen, 32'd0);
    send(0, 8'hFF);
    wait_rx(0, rc + 1, 50);
    chk("fresh_ff", {24'b0, last_word[0]}, 32'h0FF);
    repeat (20) @(negedge clk);
    chk("no_extra", rx_cnt[0], rc + 1);

    // Random streaming on both instances
    b0 = rx_cnt[0];
    b1 = rx_cnt[1];
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(0, 8'($urandom));
        end
      end
      begin
        for (int j = 0; j < 60; j++) begin
          repeat ($urandom_range(0, 12)) @(negedge clk);
          send(1, 8'($urandom));
        end
      end
    join
    wait_rx(0, b0 + 200, 6000);
    wait_rx(1, b1 + 60, 3000);
    chk("q0_empty", expq0.size(), 32'd0);
    chk("q1_empty", expq1.size(), 32'd0);
    repeat (4) @(negedge clk);
    chk("end_busy0", {31'b0, obusy[0]}, 32'd0);
    chk("end_busy1", {31'b0, obusy[1]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
